traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker at the consumer end of the traffic-light controller's `light` interface. It watches `light[2:0]`, `enable` and `error_status` alongside the controller's `timer_config`. It verifies encoding, state order (RED→GREEN→YELLOW→RED) and per-state dwell times in clock cycles, and reports violations and a count of clean cycles. It sits beside the controller in the top level and in benches, and never drives the controller.

## Interface
- No parameters; field widths fixed (6-bit durations, 18-bit config).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: controller run/pause, same signal fed to the controller.
- `timer_config` input 18: RED[17:12], YELLOW[11:6], GREEN[5:0]; dwell in cycles.
- `light` input 3: one-hot controller output; 100 RED, 010 YELLOW, 001 GREEN.
- `error_status` input 1: controller config-error flag.
- `clear` input 1: clears sticky violation state and `pass_count`.
- `in_sync` output 1: monitor is tracking (TRACK state).
- `violation` output 1: one-cycle pulse per detected violation.
- `violation_code` output 3: sticky code of first violation since reset/clear; 0 = none.
- `dwell_valid` output 1: one-cycle pulse when a state is left.
- `measured_dwell` output 7: cycles spent in the state just left; valid with `dwell_valid`.
- `pass_count` output 16: completed correctly timed RED→GREEN→YELLOW→RED loops, saturating at 0xFFFF.

## Operation
- Registers: `prev_light`, `dwell_cnt[6:0]` (saturates at 127), `exp_dwell[5:0]`, `state` ∈ {UNSYNC, TRACK}, `loop_ok`.
- Reset or `error_status`=1: state←UNSYNC; `dwell_cnt`←0; `loop_ok`←0. `error_status` preserves `violation_code` and `pass_count`.
- UNSYNC: the first change of `light` to a legal one-hot value different from `prev_light` enters TRACK. It sets `dwell_cnt`←1 and latches `exp_dwell` from the matching `timer_config` field at that edge. No checks run in UNSYNC.
- TRACK, every edge:
  - `light` unchanged, `enable`=1: `dwell_cnt`++.
  - `light` unchanged, `enable`=0: `dwell_cnt` holds.
  - `light` changed: emit `dwell_valid`/`measured_dwell`=`dwell_cnt`, then check and reload as on entry.
- Violation codes, priority high→low; one code per cycle:
  - 1 ILLEGAL_ENC: `light` not one-hot. Forces UNSYNC.
  - 5 PAUSE_CHANGE: `light` changed while `enable`=0.
  - 2 BAD_ORDER: successor not per RED→GREEN→YELLOW→RED.
  - 3 DWELL_SHORT: change with `dwell_cnt` < `exp_dwell`.
  - 4 DWELL_LONG: `light` unchanged, `enable`=1, `dwell_cnt` == `exp_dwell` (would exceed). Flag once per state visit.
- Codes 2–5 stay in TRACK and resynchronise to the new state.
- `violation_code` latches only when currently 0. `clear` zeroes it and `pass_count`.
- `loop_ok`:
  - Set on entering GREEN from RED with no violation during that RED.
  - Cleared by any violation.
  - When a clean YELLOW→RED transition occurs with `loop_ok`=1, `pass_count`++.
- `timer_config` changes mid-state do not affect `exp_dwell` until the next state entry.

## Timing
- All outputs registered. A violation on `light` sampled at edge N appears on `violation`/`violation_code` after edge N and is visible in cycle N+1.
- `dwell_valid` and `violation` are single-cycle pulses.
- Reset values: `in_sync`=0, `violation`=0, `violation_code`=0, `dwell_valid`=0, `measured_dwell`=0, `pass_count`=0.
- `reset` overrides `clear`. `clear` in the same cycle as a new violation: the cleared state wins and the new code is dropped; the `violation` pulse still fires.
- `error_status` and a `light` change in the same cycle: `error_status` wins, with no check and no pulse.
- Minimum dwell 1: a state lasting one cycle with `exp_dwell`=1 is clean.

## Structure
- `traffic_light_pkg`: light encodings (RED/YELLOW/GREEN), violation code constants, config field bit positions, `next_light` successor function.
- One sub-module: `traffic_dwell_counter` (load/increment/hold, saturation, compare against `exp_dwell`).

## Test plan
- Reset, config R=2/Y=3/G=4, ideal sequence for 3 loops → `in_sync`=1 after first transition; no `violation`; `pass_count`=2 (first loop entered mid-state is not counted); `measured_dwell` 4,3,2 in order.
- GREEN held 6 cycles with G=4 → code 4 pulse exactly at the 5th enabled GREEN cycle; one pulse only; `pass_count` unchanged for that loop.
- `light`=3'b110 for one cycle → code 1, `in_sync`=0 next cycle, resync on next legal transition.
- `enable`=0 for 10 cycles mid-RED with `light` steady → no violation, dwell held; then RED→GREEN while `enable`=0 → code 5.
- RED→YELLOW transition → code 2; `violation_code` stays 2 after a later DWELL_SHORT; `clear` → 0.
- `error_status`=1 for 5 cycles with an illegal sequence → no pulses, `in_sync`=0; recovery and a clean loop → `pass_count` increments.

Source files
------------

// File: rtl/traffic_light_monitor_pkg.sv
// Shared encodings, violation codes and config field helpers for the
// traffic-light monitor.
package traffic_light_pkg;

    typedef enum logic {ST_UNSYNC, ST_TRACK} mon_state_e;

    localparam int DUR_W = 6;
    localparam int CNT_W = 7;
    localparam int CFG_W = 18;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [2:0] VC_NONE         = 3'd0;
    localparam logic [2:0] VC_ILLEGAL_ENC  = 3'd1;
    localparam logic [2:0] VC_BAD_ORDER    = 3'd2;
    localparam logic [2:0] VC_DWELL_SHORT  = 3'd3;
    localparam logic [2:0] VC_DWELL_LONG   = 3'd4;
    localparam logic [2:0] VC_PAUSE_CHANGE = 3'd5;

    localparam int CFG_RED_LSB    = 12;
    localparam int CFG_YELLOW_LSB = 6;
    localparam int CFG_GREEN_LSB  = 0;

    function automatic logic is_legal(input logic [2:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
    endfunction

    function automatic logic [2:0] next_light(input logic [2:0] l);
        case (l)
            LIGHT_RED:    return LIGHT_GREEN;
            LIGHT_GREEN:  return LIGHT_YELLOW;
            LIGHT_YELLOW: return LIGHT_RED;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic [DUR_W-1:0] cfg_field(input logic [2:0] l,
                                                   input logic [CFG_W-1:0] cfg);
        case (l)
            LIGHT_RED:    return cfg[CFG_RED_LSB    +: DUR_W];
            LIGHT_YELLOW: return cfg[CFG_YELLOW_LSB +: DUR_W];
            LIGHT_GREEN:  return cfg[CFG_GREEN_LSB  +: DUR_W];
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Controller-side light bus as observed by the monitor; the monitor only
// ever connects through the slave modport.
interface traffic_light_monitor_if;
    import traffic_light_pkg::*;

    logic [2:0]       light;
    logic             enable;
    logic             error_status;
    logic [CFG_W-1:0] timer_config;

    modport master (output light, enable, error_status, timer_config);
    modport slave  (input  light, enable, error_status, timer_config);
endinterface

// File: rtl/traffic_light_monitor_dwell_counter.sv
// Per-state dwell counter: clear, load-to-one with expected dwell latch,
// saturating increment, and comparisons against the expected dwell.
module traffic_dwell_counter
    import traffic_light_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [DUR_W-1:0] i_exp_load,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_short,
    output logic             o_at_limit
);
    logic [CNT_W-1:0] r_cnt;
    logic [DUR_W-1:0] r_exp;
    logic [CNT_W-1:0] w_exp_ext;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_exp <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
            r_exp <= i_exp_load;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_exp_ext  = {1'b0, r_exp};
    assign o_cnt      = r_cnt;
    assign o_short    = (r_cnt < w_exp_ext);
    // Equality means one more enabled cycle would exceed the programmed dwell.
    assign o_at_limit = (r_cnt == w_exp_ext);
endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the traffic-light controller output: encoding, order
// and dwell timing, with sticky first-violation code and clean-loop count.
module traffic_light_monitor
    import traffic_light_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    traffic_light_monitor_if.slave tl,
    output logic                  o_in_sync,
    output logic                  o_violation,
    output logic [2:0]            o_violation_code,
    output logic                  o_dwell_valid,
    output logic [CNT_W-1:0]      o_measured_dwell,
    output logic [15:0]           o_pass_count
);
    mon_state_e       r_state, w_state_n;
    logic [2:0]       r_prev_light;
    logic             r_loop_ok, w_loop_ok_n;
    logic             r_visit_ok, w_visit_ok_n;
    logic             w_cnt_clr, w_cnt_load, w_cnt_inc;
    logic [2:0]       w_code;
    logic             w_viol, w_dv, w_pass_inc;
    logic             w_legal, w_changed, w_short, w_at_limit;
    logic [CNT_W-1:0] w_cnt;

    assign w_legal   = is_legal(tl.light);
    assign w_changed = (tl.light != r_prev_light);

    traffic_dwell_counter u_dwell (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_inc      (w_cnt_inc),
        .i_exp_load (cfg_field(tl.light, tl.timer_config)),
        .o_cnt      (w_cnt),
        .o_short    (w_short),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        w_state_n    = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_inc    = 1'b0;
        w_code       = VC_NONE;
        w_dv         = 1'b0;
        w_loop_ok_n  = r_loop_ok;
        w_visit_ok_n = r_visit_ok;
        w_pass_inc   = 1'b0;
        if (tl.error_status) begin
            w_state_n   = ST_UNSYNC;
            w_cnt_clr   = 1'b1;
            w_loop_ok_n = 1'b0;
        end else begin
            unique case (r_state)
                ST_UNSYNC: begin
                    // Entry is mid-loop, so the state just entered never counts as clean.
                    if (w_legal && w_changed) begin
                        w_state_n    = ST_TRACK;
                        w_cnt_load   = 1'b1;
                        w_visit_ok_n = 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (!w_legal) begin
                        w_code    = VC_ILLEGAL_ENC;
                        w_dv      = 1'b1;
                        w_state_n = ST_UNSYNC;
                        w_cnt_clr = 1'b1;
                    end else if (w_changed) begin
                        w_dv       = 1'b1;
                        w_cnt_load = 1'b1;
                        if (!tl.enable)
                            w_code = VC_PAUSE_CHANGE;
                        else if (next_light(r_prev_light) != tl.light)
                            w_code = VC_BAD_ORDER;
                        else if (w_short)
                            w_code = VC_DWELL_SHORT;
                        if (w_code == VC_NONE) begin
                            if (r_prev_light == LIGHT_RED && tl.light == LIGHT_GREEN)
                                w_loop_ok_n = r_visit_ok;
                            if (r_prev_light == LIGHT_YELLOW && tl.light == LIGHT_RED && r_loop_ok)
                                w_pass_inc = 1'b1;
                        end
                        w_visit_ok_n = (w_code == VC_NONE);
                    end else if (tl.enable) begin
                        w_cnt_inc = 1'b1;
                        if (w_at_limit) begin
                            w_code       = VC_DWELL_LONG;
                            w_visit_ok_n = 1'b0;
                        end
                    end
                end
                default: w_state_n = ST_UNSYNC;
            endcase
        end
        w_viol = (w_code != VC_NONE);
        if (w_viol)
            w_loop_ok_n = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= ST_UNSYNC;
            r_prev_light     <= tl.light;
            r_loop_ok        <= 1'b0;
            r_visit_ok       <= 1'b0;
            o_violation      <= 1'b0;
            o_violation_code <= VC_NONE;
            o_dwell_valid    <= 1'b0;
            o_measured_dwell <= '0;
            o_pass_count     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_prev_light  <= tl.light;
            r_loop_ok     <= w_loop_ok_n;
            r_visit_ok    <= w_visit_ok_n;
            o_violation   <= w_viol;
            o_dwell_valid <= w_dv;
            if (w_dv)
                o_measured_dwell <= w_cnt;
            // Clear beats a same-cycle violation or loop completion.
            if (i_clear) begin
                o_violation_code <= VC_NONE;
                o_pass_count     <= '0;
            end else begin
                if (w_viol && o_violation_code == VC_NONE)
                    o_violation_code <= w_code;
                if (w_pass_inc && o_pass_count != 16'hFFFF)
                    o_pass_count <= o_pass_count + 16'd1;
            end
        end
    end

    assign o_in_sync = (r_state == ST_TRACK);
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: directed scenarios plus random light sequences, checked
// against a behavioural model of the monitoring rules.
module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic        in_sync, violation, dwell_valid;
    logic [2:0]  violation_code;
    logic [6:0]  measured_dwell;
    logic [15:0] pass_count;
    logic [17:0] cfg;
    logic [2:0]  cur_l;

    traffic_light_monitor_if tl_if();

    traffic_light_monitor dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_clear          (clear),
        .tl               (tl_if),
        .o_in_sync        (in_sync),
        .o_violation      (violation),
        .o_violation_code (violation_code),
        .o_dwell_valid    (dwell_valid),
        .o_measured_dwell (measured_dwell),
        .o_pass_count     (pass_count)
    );

    always #5 clk = ~clk;

    typedef struct {int in_sync; int code; int pass;} st_t;
    typedef struct {int cyc; int meas;} dv_t;
    st_t stq[$];
    int  vq[$];
    dv_t dq[$];

    int n_checks = 0, n_errors = 0;
    int dcyc = 0, mcyc = 0;

    function automatic void check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, mcyc, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    int m_track, m_cnt, m_exp, m_loop, m_visit, m_code, m_pass;
    logic [2:0] m_prev;

    function automatic int lidx(logic [2:0] l);
        case (l)
            3'b100:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int dur(logic [2:0] l, logic [17:0] c);
        case (lidx(l))
            0:       return int'(c[17:12]);
            1:       return int'(c[5:0]);
            2:       return int'(c[11:6]);
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic [2:0] l, input bit en, err, clr, rst);
        int vc = 0, meas = 0;
        bit dv = 0, pinc = 0;
        if (rst) begin
            m_track = 0; m_cnt = 0; m_loop = 0; m_visit = 0; m_code = 0; m_pass = 0;
        end else begin
            if (err) begin
                m_track = 0; m_cnt = 0; m_loop = 0;
            end else if (m_track == 0) begin
                if (lidx(l) >= 0 && l != m_prev) begin
                    m_track = 1; m_cnt = 1; m_exp = dur(l, cfg); m_visit = 0;
                end
            end else if (lidx(l) < 0) begin
                vc = 1; dv = 1; meas = m_cnt;
                m_track = 0; m_cnt = 0; m_loop = 0;
            end else if (l != m_prev) begin
                dv = 1; meas = m_cnt;
                if (!en) vc = 5;
                else if (lidx(l) != (lidx(m_prev) + 1) % 3) vc = 2;
                else if (m_cnt < m_exp) vc = 3;
                if (vc != 0) m_loop = 0;
                else if (m_prev == R && l == G) m_loop = m_visit;
                else if (m_prev == Y && l == R && m_loop != 0) pinc = 1;
                m_visit = (vc == 0);
                m_cnt = 1; m_exp = dur(l, cfg);
            end else if (en) begin
                if (m_cnt == m_exp) begin
                    vc = 4; m_loop = 0; m_visit = 0;
                end
                if (m_cnt < 127) m_cnt++;
            end
            if (clr) begin
                m_code = 0; m_pass = 0;
            end else begin
                if (vc != 0 && m_code == 0) m_code = vc;
                if (pinc && m_pass < 65535) m_pass++;
            end
        end
        m_prev = l;
        stq.push_back('{m_track, m_code, m_pass});
        if (vc != 0) vq.push_back(dcyc);
        if (dv) dq.push_back('{dcyc, meas});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] l, input bit en = 1'b1, input bit err = 1'b0,
                         input bit clr = 1'b0, input bit rst = 1'b0);
        tl_if.light        = l;
        tl_if.enable       = en;
        tl_if.error_status = err;
        tl_if.timer_config = cfg;
        clear = clr;
        reset = rst;
        model_step(l, en, err, clr, rst);
        dcyc++;
        cur_l = l;
        @(negedge clk);
    endtask

    task automatic hold(input logic [2:0] l, input int n, input bit en = 1'b1);
        repeat (n) drive(l, en);
    endtask

    task automatic loops(input int n);
        repeat (n) begin
            hold(G, dur(G, cfg));
            hold(Y, dur(Y, cfg));
            hold(R, dur(R, cfg));
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stq.size() > 0) begin
                st_t s;
                bit  exp_v, exp_d;
                dv_t d;
                s = stq.pop_front();
                check("in_sync", int'(in_sync), s.in_sync);
                check("violation_code", int'(violation_code), s.code);
                check("pass_count", int'(pass_count), s.pass);
                exp_v = (vq.size() > 0 && vq[0] == mcyc);
                if (exp_v) void'(vq.pop_front());
                if (violation || exp_v) check("violation_pulse", int'(violation), int'(exp_v));
                exp_d = (dq.size() > 0 && dq[0].cyc == mcyc);
                if (exp_d) d = dq.pop_front();
                if (dwell_valid || exp_d) check("dwell_valid_pulse", int'(dwell_valid), int'(exp_d));
                if (dwell_valid && exp_d) check("measured_dwell", int'(measured_dwell), d.meas);
                mcyc++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        cfg = {6'd2, 6'd3, 6'd4};
        drive(R, 1, 0, 0, 1);
        drive(R, 1, 0, 1, 1);
        check("reset_in_sync", int'(in_sync), 0);
        check("reset_violation", int'(violation), 0);
        check("reset_code", int'(violation_code), 0);
        check("reset_dwell_valid", int'(dwell_valid), 0);
        check("reset_measured", int'(measured_dwell), 0);
        check("reset_pass", int'(pass_count), 0);

        // ideal loops; first loop was joined mid-RED
        hold(R, 1);
        loops(3);
        check("ideal_pass", int'(pass_count), 2);
        check("ideal_code", int'(violation_code), 0);
        check("ideal_in_sync", int'(in_sync), 1);

        // GREEN overstays
        hold(G, 6);
        check("long_code", int'(violation_code), 4);
        hold(Y, 3); hold(R, 2);
        check("long_pass_unchanged", int'(pass_count), 2);
        loops(1);
        check("pass_after_clean", int'(pass_count), 3);
        hold(G, 3); drive(G, 1, 0, 1);
        check("clear_code", int'(violation_code), 0);
        check("clear_pass", int'(pass_count), 0);

        // illegal encoding and resync
        drive(3'b110);
        check("illegal_code", int'(violation_code), 1);
        check("illegal_unsync", int'(in_sync), 0);
        hold(Y, 3);
        check("resync", int'(in_sync), 1);
        hold(R, 2); hold(G, 3); drive(G, 1, 0, 1);

        // pause mid-RED, then change while paused
        hold(Y, 3); hold(R, 1); hold(R, 10, 0); hold(R, 1);
        check("pause_no_viol", int'(violation_code), 0);
        drive(G, 0);
        check("pause_change_code", int'(violation_code), 5);
        hold(G, 3); hold(Y, 3); hold(R, 2); hold(G, 3); drive(G, 1, 0, 1);

        // bad order, sticky against a later short dwell, clear racing a violation
        hold(Y, 3); hold(R, 2);
        drive(Y);
        drive(R);
        check("bad_order_sticky", int'(violation_code), 2);
        hold(R, 1); drive(R, 1, 0, 1);
        check("clear_wins", int'(violation_code), 0);

        // error_status masks an illegal sequence
        drive(3'b110, 1, 1); drive(3'b000, 1, 1); drive(3'b111, 1, 1);
        drive(R, 1, 1); drive(Y, 1, 1);
        check("error_unsync", int'(in_sync), 0);
        check("error_code", int'(violation_code), 0);
        loops(2);
        check("error_recovery_pass", int'(pass_count), 1);

        // minimum dwell of one cycle
        cfg = {6'd1, 6'd1, 6'd1};
        loops(3);
        check("min_dwell_code", int'(violation_code), 0);

        // random sequences
        for (int k = 0; k < 120; k++) begin
            logic [2:0] nl;
            int r, d;
            logic [2:0] legal_l [3];
            legal_l = '{R, G, Y};
            r = int'($urandom_range(0, 99));
            if (r < 80)      nl = legal_l[(lidx(cur_l) < 0) ? 0 : (lidx(cur_l) + 1) % 3];
            else if (r < 90) nl = legal_l[$urandom_range(0, 2)];
            else             nl = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                cfg = {6'($urandom_range(1, 5)), 6'($urandom_range(1, 5)), 6'($urandom_range(1, 5))};
            d = dur(nl, cfg) + int'($urandom_range(0, 2)) - 1;
            if (d < 1) d = 1;
            for (int j = 0; j < d; j++)
                drive(nl, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                      $urandom_range(0, 59) == 0, 1'b0);
        end

        // reset beats clear
        drive(R, 1, 0, 1, 1);
        check("final_reset_code", int'(violation_code), 0);
        check("final_reset_pass", int'(pass_count), 0);
        check("scoreboard_drained", stq.size() + vq.size() + dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
